// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
// The pipeline side is the master; the unit itself uses the slave modport.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, flush,
        input  stall, busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, flush,
        output stall, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO registers.
// One result bit per cycle; a final FIX cycle applies the sign correction and commits HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div0_q, div0_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0]   prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvsr_d    = dvsr_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = div0_q;

        signed_op = ~bus.op[0];
        a_mag     = magnitude(bus.op_a, signed_op);
        b_mag     = magnitude(bus.op_b, signed_op);
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvsr_q : '0)};
        rem_sh    = {rem_q, acc_q[WIDTH-1]};
        rem_diff  = rem_sh - {2'b00, dvsr_q};
        prod_fix  = neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (!bus.op[2]) begin
                        is_div_d  = bus.op[1];
                        neg_d     = signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        neg_rem_d = signed_op & bus.op_a[WIDTH-1];
                        dz_d      = bus.op[1] & (bus.op_b == '0);
                        // Divide keeps the divisor in dvsr and the dividend in acc's low half;
                        // multiply keeps the multiplicand in dvsr and the multiplier in acc.
                        dvsr_d    = bus.op[1] ? b_mag : a_mag;
                        acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        rem_d     = '0;
                        cnt_d     = CNT_W'(WIDTH);
                        div0_d    = 1'b0;
                        state_d   = CALC;
                    end else if (bus.op == 3'd4) begin
                        hi_d = bus.op_a;
                    end else if (bus.op == 3'd5) begin
                        lo_d = bus.op_a;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (rem_diff[WIDTH+1]) begin
                            rem_d = rem_sh[WIDTH:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                        end else begin
                            rem_d = rem_diff[WIDTH:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // With a zero divisor the remainder is |op_a|, so the remainder sign
                        // fix-up hands back op_a exactly; the quotient is forced to all ones.
                        hi_d   = apply_sign(rem_q[WIDTH-1:0], neg_rem_q);
                        lo_d   = dz_q ? '1 : apply_sign(acc_q[WIDTH-1:0], neg_q);
                        div0_d = dz_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    always_ff @(posedge clk) begin
        dvsr_q    <= dvsr_d;
        acc_q     <= acc_d;
        rem_q     <= rem_d;
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.stall = (state_q != IDLE) | (bus.start & ~bus.op[2]);
    assign bus.done  = done_q;
    assign bus.div0  = div0_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the execute stage, with architectural HI/LO registers.
- Replaces the single-cycle MUL/DIV ALU ops with a parametrised multi-cycle engine: signed and unsigned multiply and divide, plus MTHI/MTLO writes.
- Drives a stall request so the hazard logic can freeze IF/ID/EX while an operation runs.
- Sits beside the ALU; operands arrive already forwarded.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  request; sampled each rising edge.
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 are no-ops.
op_a  in  WIDTH  multiplicand / dividend / MTHI/MTLO data (forwarded rs).
op_b  in  WIDTH  multiplier / divisor (forwarded rt).
flush  in  1  kill the operation in progress (branch/exception squash).
stall  out  1  combinational: busy | (start & op<=3).
busy  out  1  registered: state != IDLE.
done  out  1  one-cycle pulse when HI/LO take a mul/div result.
div0  out  1  registered; set with done when a divide had op_b==0, cleared on the next accepted start.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
Reset:
- While rst_n==0 at an edge: state=IDLE, counter=0, hi=0, lo=0, done=0, div0=0.
- Reset has priority over flush and start.
- Reset during CALC/FIX abandons the operation. No done pulse.

FSM states: IDLE, CALC, FIX.
IDLE:
- start & op<=3 at edge t0: latch |op_a| and |op_b|, record result signs (signed ops only), clear accumulators, counter=WIDTH, go to CALC, clear div0.
- start & op==4: hi<=op_a at that edge. op==5: lo<=op_a. Stay IDLE, no done.
- op 6/7: ignored.
CALC:
- One iteration per cycle, counter decrements; at counter==1 go to FIX.
- Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product.
- Divide: restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
FIX:
- Apply sign correction.
- Write hi/lo at the edge leaving FIX, go to IDLE, done=1 for the following cycle.
- Latency: hi/lo valid and done=1 in the cycle after edge t0+WIDTH+1. busy is 1 for exactly WIDTH+1 cycles.
Results:
- MULT/MULTU: {hi,lo} = full 2*WIDTH product; MULT is two's-complement signed.
- DIV/DIVU: lo=quotient, hi=remainder.
- Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (op_b==0): lo=all ones, hi=op_a unmodified, div0=1 with done. No sign correction in this case.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, div0=0.
Boundaries:
- start while busy: ignored (no queue). stall keeps the pipeline from issuing it; if it arrives anyway, it is dropped.
- flush while busy: return to IDLE at that edge; hi/lo unchanged; no done.
- flush together with start in IDLE: start ignored, including MTHI/MTLO.
- MTHI/MTLO while busy: ignored.
- hi/lo are readable (MFHI/MFLO) any time. During an operation they hold the previous values.
- done and a new start in the same cycle: start accepted normally.

Test Plan:
1. WIDTH=32. MULT op_a=FFFFFFFD (-3), op_b=5.
   -> busy high for 33 cycles; done pulse; hi=FFFFFFFF, lo=FFFFFFF1.
2. MULTU FFFFFFFF*00000002.
   -> hi=00000001, lo=FFFFFFFE.
3. DIV -7/2, then DIVU 7/2.
   -> DIV: lo=FFFFFFFD, hi=FFFFFFFF. DIVU: lo=3, hi=1.
4. DIVU 7/0, then DIV 80000000/FFFFFFFF.
   -> first: lo=FFFFFFFF, hi=7, div0=1. second: lo=80000000, hi=0, div0=0.
5. MTHI 12345678, then MULT 2*3 with flush at cycle 10 of CALC.
   -> busy drops the next cycle; no done; hi=12345678 and lo unchanged.
   A start (MTLO AAAAAAAA) issued mid-operation is ignored.
6. rst_n=0 for one edge mid-DIV, then MULTU 4*4.
   -> all outputs 0 after reset; no done from the killed DIV.
   MULTU gives hi=0, lo=10 after 33 cycles.
